nibble_add_sequencer: RTL
=========================

// Module: nibble_add_sequencer
// PURPOSE
//  Adds two WIDTH-bit operands using one shared 4-bit adder slice, one nibble per cycle, LSB first.
//  Carry is held in a register between nibbles.
//  Supports add and subtract (two's complement).
//  Accepts requests on a valid/ready input and returns results on a valid/ready output.
//  Sits between the operand source and any consumer that needs a WIDTH-bit sum from 4-bit hardware.
// PARAMETERS
//  WIDTH   16   operand/result width; must be a multiple of 4 and >= 8
//  NIB     WIDTH/4 (localparam)   number of nibble passes per operation
// PORTS
//  clk        in   1      rising-edge clock (single clock domain)
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      block can accept a request; equals (state==IDLE)
//  op_sub     in   1      0: a+b, 1: a-b; sampled with the request
//  a          in   WIDTH  operand A; sampled on accept
//  b          in   WIDTH  operand B; sampled on accept
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB nibble (borrow-free flag when op_sub=1)
//  ovf        out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0,
//    idx=0, carry reg=0. Any in-flight operation is discarded and no out_valid is produced.
//  - States:
//    - IDLE: accept when in_valid && in_ready.
//      - Capture a_r=a and b_r = op_sub ? ~b : b.
//      - Set carry=op_sub, idx=0, sum=0. Go to RUN.
//    - RUN: each cycle compute {c,s} = a_r[idx*4+:4] + b_r[idx*4+:4] + carry.
//      - Write sum[idx*4+:4]=s; carry<=c; idx<=idx+1.
//      - On the MSB pass (idx==NIB-1): cout<=c, ovf<=c_into_bit3 ^ c, then go to DONE.
//    - DONE: out_valid=1. sum/cout/ovf are held stable until out_ready=1.
//      - On handshake: out_valid<=0, go to IDLE.
//  - Latency: the acceptance edge is cycle 0; out_valid is first high in cycle NIB (4 for WIDTH=16).
//  - Minimum spacing between accepts: NIB+2 cycles (one DONE handshake cycle, one IDLE cycle).
//  - in_ready=0 in RUN and DONE. in_valid there is ignored; the source must hold its request.
//  - Changes on a/b/op_sub after accept have no effect on the current operation.
//  - out_ready held low indefinitely: stay in DONE; outputs do not change.
//  - idx is $clog2(NIB) bits wide. It wraps only through the DONE->IDLE reset to 0, never mid-operation.
//  - Width rules: nibble add is 4+4+1 -> 5 bits. Sum is exact modulo 2^WIDTH.
//  - Partial sum bits are visible on sum during RUN, but are valid only while out_valid=1.
// STRUCTURE
//  - Shared package nib_seq_pkg: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and NIBBLE_W=4.
//  - One sub-module: nibble_adder_cin, a combinational 4-bit ripple adder.
//    - Ports a[3:0], b[3:0], cin -> s[3:0], c3 (carry into bit 3), c4.
//    - Instantiated once and driven from the idx-selected operand slices.
//  - The controller FSM, index counter, carry register and result register live in the top.
// TESTING
//  1. add 16'h00FF+16'h0001 -> sum=16'h0100, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
//  2. add 16'hFFFF+16'h0001 -> sum=16'h0000, cout=1, ovf=0.
//     add 16'h7FFF+16'h0001 -> sum=16'h8000, cout=0, ovf=1.
//  3. sub 16'h0005-16'h0007 -> sum=16'hFFFE, cout=0, ovf=0.
//     sub 16'h8000-16'h0001 -> sum=16'h7FFF, cout=1, ovf=1.
//  4. out_ready low 5 cycles in DONE -> sum/cout/ovf stable, in_ready=0.
//     A second in_valid during that time is not accepted. It is accepted one cycle after the result handshake.
//  5. rst_n pulsed low during RUN with idx=2 -> outputs are immediately at reset values and no out_valid follows.
//     The next request 16'h1234+16'h1111 returns 16'h2345.
//  6. sweep i=0..15 with a=b=i*16'h1111, both op_sub values; compare against a behavioural model.
//     Check that latency is constant at 4 for every case.

Source files
------------

// File: rtl/nib_seq_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package nib_seq_pkg;

    localparam int NIBBLE_W = 4;

    // Controller states; the encoding is also visible on the debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder_cin.sv
// Combinational 4-bit ripple adder with carry-in. It also exposes the carry
// into bit 3 so the caller can form signed overflow on the MSB nibble.
module nibble_adder_cin
    import nib_seq_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                c3,
    output logic                c4
);

    logic [NIBBLE_W:0] c;

    // Ripple the carry through the four bit positions.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        c3 = c[NIBBLE_W-1];
        c4 = c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_add_sequencer.sv
// WIDTH-bit add/subtract built from one shared 4-bit adder slice, one nibble
// per cycle, LSB first. Requests arrive on in_valid/in_ready and results leave
// on out_valid/out_ready.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; the producer must hold valid (and its data) until that edge, and ready
// may depend on state but never on the partner's valid.
module nibble_add_sequencer
    import nib_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;

    logic [NIBBLE_W-1:0] nib_a, nib_b, nib_s;
    logic                nib_c3, nib_c4;

    // Select the operand nibbles for the current pass.
    always_comb begin
        nib_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
    end

    nibble_adder_cin u_adder (
        .a   (nib_a),
        .b   (nib_b),
        .cin (carry_q),
        .s   (nib_s),
        .c3  (nib_c3),
        .c4  (nib_c4)
    );

    // Next-state logic: accept in IDLE, one nibble per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + 1: invert B now, seed the carry with 1.
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = nib_s;
                carry_d = nib_c4;
                if (idx_q == IDX_LAST) begin
                    cout_d  = nib_c4;
                    ovf_d   = nib_c3 ^ nib_c4;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags and results come straight from the registers.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
        state_dbg = state_q;
    end

endmodule
